// File: rtl/cmp_sweep_sched.sv
// cmp_sweep_sched: steps bank/group selects through all 16 combinations, samples cmp_hit per step.
// Latency: each step costs settle+1 cycles; done pulses the cycle after the last sample.
// Backpressure: none; start is ignored while busy, abort returns to IDLE without done.
// Optional macro SWEEP_EARLY_EXIT_EN: the first sampled hit ends the sweep.
module cmp_sweep_sched #(
  parameter int SETTLE_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [SETTLE_W-1:0] settle_cfg,
  input  logic                carry_cfg,
  input  logic                cmp_hit,
  output logic [1:0]          bank_sel,
  output logic [1:0]          grp_sel,
  output logic                carry_in,
  output logic                busy,
  output logic                done,
  output logic                hit_any,
  output logic [3:0]          first_idx,
  output logic [15:0]         hit_map
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [SETTLE_W-1:0] CNT_ONE = {{(SETTLE_W-1){1'b0}}, 1'b1};

  state_t              state;
  logic [3:0]          idx;
  logic [SETTLE_W-1:0] cnt;
  logic [SETTLE_W-1:0] settle_lat;
  logic                last_step;

  // The step index drives the selects directly; bank is the fast-moving half.
  assign bank_sel = idx[1:0];
  assign grp_sel  = idx[3:2];

  // Decide whether the current sample ends the sweep.
  always_comb begin
    last_step = (idx == 4'hF);
`ifdef SWEEP_EARLY_EXIT_EN
    if (cmp_hit) begin
      last_step = 1'b1;
    end
`endif
  end

  // Sweep sequencer: latch config at start, count settle, sample, advance, finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 4'd0;
      cnt        <= '0;
      settle_lat <= '0;
      carry_in   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hit_any    <= 1'b0;
      first_idx  <= 4'hF;
      hit_map    <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          // abort has priority over start so a colliding request is dropped
          if (start && !abort) begin
            state      <= SETTLE;
            busy       <= 1'b1;
            idx        <= 4'd0;
            cnt        <= settle_cfg;
            settle_lat <= settle_cfg;
            carry_in   <= carry_cfg;
            hit_map    <= 16'h0000;
            first_idx  <= 4'hF;
            hit_any    <= 1'b0;
          end
        end
        SETTLE: begin
          if (abort) begin
            // partial results are kept; the in-flight sample is discarded
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            hit_map[idx] <= cmp_hit;
            if (cmp_hit && !hit_any) begin
              first_idx <= idx;
              hit_any   <= 1'b1;
            end
            if (last_step) begin
              // idx is left in place so the selects hold the final step
              state <= FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx <= idx + 4'd1;
              cnt <= settle_lat;
            end
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_sweep_sched.sv
// tb_cmp_sweep_sched: directed plus randomized sweeps of cmp_sweep_sched.
// Expected timing and results come from step arithmetic: step i samples at cycle (i+1)*(settle+1) after start.
// The comparator is modelled as a 16-entry hit pattern indexed by {grp_sel, bank_sel}.
module tb_cmp_sweep_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [3:0]  settle_cfg;
  logic        carry_cfg;
  logic        cmp_hit;
  logic [1:0]  bank_sel;
  logic [1:0]  grp_sel;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic        hit_any;
  logic [3:0]  first_idx;
  logic [15:0] hit_map;
  logic [15:0] pattern;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign cmp_hit = pattern[{grp_sel, bank_sel}];

  cmp_sweep_sched #(.SETTLE_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .settle_cfg (settle_cfg),
    .carry_cfg  (carry_cfg),
    .cmp_hit    (cmp_hit),
    .bank_sel   (bank_sel),
    .grp_sel    (grp_sel),
    .carry_in   (carry_in),
    .busy       (busy),
    .done       (done),
    .hit_any    (hit_any),
    .first_idx  (first_idx),
    .hit_map    (hit_map)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int first_set(input logic [15:0] m);
    for (int i = 0; i < 16; i++) begin
      if (m[i]) return i;
    end
    return 15;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_results(input string tag, input logic [15:0] m);
    check_eq({tag, "_map"}, hit_map, m);
    check_eq({tag, "_first"}, first_idx, first_set(m));
    check_eq({tag, "_any"}, hit_any, |m);
  endtask

  // One sweep: settle s, comparator pattern pat, carry c, abort in cycle abort_at after start (0 = never).
  // noisy: change config after start and pulse start mid-sweep; neither may have any effect.
  task automatic run_sweep(input int s, input logic [15:0] pat, input logic c,
                           input int abort_at, input bit noisy);
    int e;
    int len;
    logic [15:0] m;
    pattern = pat;
    e = 15;
`ifdef SWEEP_EARLY_EXIT_EN
    if (pat != 16'h0) e = first_set(pat);
`endif
    len = (e + 1) * (s + 1);
    settle_cfg = s[3:0];
    carry_cfg  = c;
    start      = 1'b1;
    tick();
    start = 1'b0;
    if (noisy) begin
      settle_cfg = (s[3:0] == 4'd7) ? 4'd1 : 4'd7;
      carry_cfg  = ~c;
    end
    for (int k = 1; k <= len; k++) begin
      check_eq("busy", busy, 1);
      check_eq("done_early", done, 0);
      check_eq("sel", {grp_sel, bank_sel}, (k - 1) / (s + 1));
      check_eq("carry", carry_in, c);
      if (noisy && (k % 5 == 0)) start = 1'b1;
      if (k == abort_at) abort = 1'b1;
      tick();
      start = 1'b0;
      if (k == abort_at) begin
        abort = 1'b0;
        m = 16'h0;
        for (int i = 0; i <= e; i++) begin
          if ((i + 1) * (s + 1) < abort_at) m[i] = pat[i];
        end
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_results("abort", m);
        tick();
        check_eq("abort_idle_busy", busy, 0);
        check_eq("abort_idle_done", done, 0);
        return;
      end
    end
    m = 16'h0;
    for (int i = 0; i <= e; i++) m[i] = pat[i];
    check_eq("done", done, 1);
    check_eq("end_busy", busy, 0);
    check_eq("end_sel", {grp_sel, bank_sel}, e);
    check_results("end", m);
    tick();
    check_eq("done_pulse", done, 0);
    check_eq("idle_busy", busy, 0);
  endtask

  initial begin
    int s;
    int ab;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    settle_cfg = 4'd0;
    carry_cfg = 1'b0;
    pattern = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_first", first_idx, 4'hF);
    check_eq("rst_map", hit_map, 0);
    rst_n = 1'b1;
    tick();

    // no hits, settle 0: done at T+17
    run_sweep(0, 16'h0000, 1'b0, 0, 1'b0);
    // single hit at bank 2, group 1 (idx 6), settle 2: done at T+49
    run_sweep(2, 16'h0040, 1'b0, 0, 1'b0);
    // hits at 3 and 12, settle changed 1 -> 7 mid-sweep, start pulses ignored
    run_sweep(1, 16'h1008, 1'b0, 0, 1'b1);
    // abort on the step-7 sample cycle with cmp_hit=1
    run_sweep(1, 16'h0080, 1'b0, 16, 1'b1);
    // carry latched at 1, cfg dropped to 0 during the sweep
    run_sweep(0, 16'h8001, 1'b1, 0, 1'b1);

    // start and abort together in IDLE: dropped
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_eq("start_abort_busy", busy, 0);
    tick();
    check_eq("start_abort_busy2", busy, 0);
    check_eq("start_abort_done", done, 0);

    for (int n = 0; n < 40; n++) begin
      s  = $urandom_range(0, 4);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16 * (s + 1)) : 0;
      run_sweep(s, 16'($urandom & $urandom), 1'($urandom), ab, 1'($urandom));
    end

    // reset in the middle of a sweep, while step 5 is selected
    pattern = 16'hFFFF;
    settle_cfg = 4'd1;
    carry_cfg = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check_eq("pre_rst_sel", {grp_sel, bank_sel}, 5);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_bank", bank_sel, 0);
    check_eq("mid_rst_grp", grp_sel, 0);
    check_eq("mid_rst_carry", carry_in, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    check_results("mid_rst", 16'h0);
    tick();
    check_eq("mid_rst_done2", done, 0);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_done", done, 0);
    run_sweep(0, 16'h0100, 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
